if_id_pipe: RTL and testbench

Fetch-side pipeline front end for the 5-stage RISC-V core. It owns the PC register and the IF/ID pipeline register, and is the consumer of the hazard unit's `stall` and `flush` requests. On a stall it freezes the PC and the IF/ID register. On a flush it redirects the PC to the resolved branch or jump target and injects a NOP bubble. A stall watchdog flags a pipeline that never recovers from a stall.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pc_reg.sv | 40 ++++
 rtl/if_id_pipe.sv | 121 ++++++++++++
 tb/tb_if_id_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and FSM encoding for the fetch-side pipeline front end.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register: async reset, hold enable and a word-aligned redirect mux.
module pc_reg
    import pipe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // NOTE: pc_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (redirect_i) begin
            pc_d = {target_i[XLEN-1:2], 2'b00};
        end else if (hold_i) begin
            pc_d = pc_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_id_pipe.sv
// PC + IF/ID pipeline register with stall/flush handling and a stall watchdog.
// Optional IF_ID_PERF_EN adds 32-bit StallCount/FlushCount performance counters.
module if_id_pipe
    import pipe_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
    parameter int              MAX_STALL = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [31:0]     InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            StallErr
`ifdef IF_ID_PERF_EN
   ,output logic [31:0]     StallCount,
    output logic [31:0]     FlushCount
`endif
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcp4;
        logic            valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pcp4: '0, valid: 1'b0};

    fetch_state_t    state_q, state_d;
    ifid_t           ifid_q, ifid_d;
    logic [7:0]      wd_q, wd_d;
    logic            err_q, err_d;
    logic            run, flush_run, stall_run;
    logic [XLEN-1:0] pc_plus4;

    assign run       = (state_q == RUN);
    assign flush_run = run & flush;
    assign stall_run = run & stall & ~flush;
    assign pc_plus4  = PCF + XLEN'(4);

    pc_reg #(
        .XLEN    (XLEN),
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .hold_i    (~run | stall),
        .redirect_i(flush_run),
        .target_i  (PCTargetE),
        .pc_o      (PCF)
    );

    always_comb begin
        state_d = RUN;
        ifid_d  = ifid_q;
        wd_d    = wd_q;
        err_d   = err_q;

        // Flush beats stall: the stalled D instruction is on the wrong path.
        if (!run || flush) begin
            ifid_d = BUBBLE;
        end else if (!stall) begin
            ifid_d = '{InstrF, PCF, pc_plus4, 1'b1};
        end

        if (stall_run) begin
            wd_d = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
            if (wd_d == 8'(MAX_STALL)) begin
                err_d = 1'b1;
            end
        end else if (!stall || !run) begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            ifid_q  <= BUBBLE;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pcp4;
    assign ValidD   = ifid_q.valid;
    assign StallErr = err_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, stall_run};
            flush_cnt_q <= flush_cnt_q + {31'd0, flush_run};
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: behavioural model, per-cycle compare, literal pins.
module tb_if_id_pipe;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
    localparam int          MAX_STALL = 15;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk, rst, stall, flush;
    logic [31:0] PCTargetE, InstrF, PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, StallErr;
`ifdef IF_ID_PERF_EN
    logic [31:0] StallCount, FlushCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_id_pipe #(.XLEN(XLEN), .RESET_PC(RESET_PC), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .PCTargetE(PCTargetE), .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .StallErr(StallErr)
`ifdef IF_ID_PERF_EN
       ,.StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    // Instruction ROM: each word is tagged with the address it came from.
    function automatic logic [31:0] tag(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0003;
    endfunction

    assign InstrF = tag(PCF);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fetch stream as plain arithmetic on a PC and a D slot.
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
    logic        m_valid, m_err, m_booted;
    int          m_run;
    logic [31:0] m_sc, m_fc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = RESET_PC; m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
            m_err = 0; m_booted = 0; m_run = 0; m_sc = 0; m_fc = 0;
        end else if (!m_booted) begin
            m_booted = 1;
        end else begin
            if (flush) begin
                m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
                m_pc = PCTargetE & ~32'd3;
                m_fc = m_fc + 1;
            end else if (stall) begin
                m_sc = m_sc + 1;
            end else begin
                m_instr = tag(m_pc); m_pcd = m_pc; m_pcp4 = m_pc + 4; m_valid = 1;
                m_pc = m_pc + 4;
            end
            if (stall && !flush) begin
                m_run++;
                if (m_run >= MAX_STALL) m_err = 1;
            end else if (!stall) begin
                m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_PCF", PCF, m_pc);
            check("model_InstrD", InstrD, m_instr);
            check("model_PCD", PCD, m_pcd);
            check("model_PCPlus4D", PCPlus4D, m_pcp4);
            check("model_ValidD", {31'd0, ValidD}, {31'd0, m_valid});
            check("model_StallErr", {31'd0, StallErr}, {31'd0, m_err});
`ifdef IF_ID_PERF_EN
            check("model_StallCount", StallCount, m_sc);
            check("model_FlushCount", FlushCount, m_fc);
`endif
        end
    end

    task automatic cyc(input logic s, input logic f, input logic [31:0] t);
        stall = s; flush = f; PCTargetE = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_PCF"}, PCF, RESET_PC);
        check({name, "_InstrD"}, InstrD, NOP);
        check({name, "_PCD"}, PCD, 32'd0);
        check({name, "_ValidD"}, {31'd0, ValidD}, 32'd0);
        check({name, "_StallErr"}, {31'd0, StallErr}, 32'd0);
`ifdef IF_ID_PERF_EN
        check({name, "_StallCount"}, StallCount, 32'd0);
        check({name, "_FlushCount"}, FlushCount, 32'd0);
`endif
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; PCTargetE = '0;
        #12;
        check_reset_state("reset");
        rst = 1'b0;

        // Boot edge, then a straight fetch stream.
        cyc(0, 0, 0);
        check("boot_PCF", PCF, 32'hBFC0_0000);
        check("boot_ValidD", {31'd0, ValidD}, 32'd0);
        cyc(0, 0, 0);
        check("fetch1_PCF", PCF, 32'hBFC0_0004);
        check("fetch1_InstrD", InstrD, 32'hBFC0_0000 ^ 32'h5A5A_0003);
        check("fetch1_PCD", PCD, 32'hBFC0_0000);
        check("fetch1_PCPlus4D", PCPlus4D, 32'hBFC0_0004);
        check("fetch1_ValidD", {31'd0, ValidD}, 32'd1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("fetch3_PCF", PCF, 32'hBFC0_000C);

        // Three stalled cycles freeze everything; the stream resumes in order.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            check("stall_PCF", PCF, 32'hBFC0_000C);
            check("stall_PCD", PCD, 32'hBFC0_0008);
        end
        cyc(0, 0, 0);
        check("resume_PCD", PCD, 32'hBFC0_000C);
        check("resume_PCF", PCF, 32'hBFC0_0010);

        // Flush redirects to an aligned target and costs one bubble.
        cyc(0, 1, 32'hBFC0_0103);
        check("flush_PCF", PCF, 32'hBFC0_0100);
        check("flush_InstrD", InstrD, NOP);
        check("flush_ValidD", {31'd0, ValidD}, 32'd0);
        cyc(0, 0, 0);
        check("flush_next_PCD", PCD, 32'hBFC0_0100);
        check("flush_next_ValidD", {31'd0, ValidD}, 32'd1);

        // Flush together with stall behaves as a plain flush.
        cyc(1, 1, 32'hBFC0_0203);
        check("fs_PCF", PCF, 32'hBFC0_0200);
        check("fs_InstrD", InstrD, NOP);
        check("fs_ValidD", {31'd0, ValidD}, 32'd0);
        cyc(0, 0, 0);
        check("fs_next_PCD", PCD, 32'hBFC0_0200);

        // PC wraps modulo 2^32.
        cyc(0, 1, 32'hFFFF_FFFE);
        check("wrap_flush_PCF", PCF, 32'hFFFF_FFFC);
        cyc(0, 0, 0);
        check("wrap_PCF", PCF, 32'h0000_0000);
        check("wrap_PCPlus4D", PCPlus4D, 32'h0000_0000);

        // Randomised traffic checked by the model every cycle.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
        end

        // Watchdog: stall/flush are ignored during BOOT, then 15 stalls set StallErr.
        rst_pulse();
        cyc(1, 1, 32'h0000_1000);
        check("boot_ignore_PCF", PCF, RESET_PC);
        check("boot_ignore_ValidD", {31'd0, ValidD}, 32'd0);
        for (int i = 0; i < 14; i++) cyc(1, 0, 0);
        check("wd_14_StallErr", {31'd0, StallErr}, 32'd0);
        cyc(1, 0, 0);
        check("wd_15_StallErr", {31'd0, StallErr}, 32'd1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("wd_sticky_StallErr", {31'd0, StallErr}, 32'd1);
        rst_pulse();
        cyc(0, 0, 0);
        check("wd_cleared_StallErr", {31'd0, StallErr}, 32'd0);

`ifdef IF_ID_PERF_EN
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        cyc(0, 1, 32'h0000_2000);
        cyc(0, 0, 0);
        cyc(1, 1, 32'h0000_3000);
        check("perf_StallCount", StallCount, 32'd5);
        check("perf_FlushCount", FlushCount, 32'd2);
        cyc(1, 0, 0);
        rst_pulse();
`endif

        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
